// File: rtl/raytracing_fb_scanout.sv
// Frame-buffer scan-out: reads the pixel RAM word by word and streams RGB565
// pixels (low half first). Read issue is credit-limited so the word FIFO can
// always absorb every in-flight read, whatever the downstream backpressure.
module raytracing_fb_scanout #(
  parameter int NUM_WORDS  = 38400,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [3:0]        ram_byteenable,
  output logic              ram_clken,
  input  logic [31:0]       ram_readdata,
  output logic [15:0]       pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sop,
  output logic              pix_eop
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PIX_W = $clog2(2 * NUM_WORDS);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS - 1);
  localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(2 * NUM_WORDS - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              inflight_q, inflight_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              half_q, half_d;
  logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [31:0]       mem_q [FIFO_DEPTH];
  logic              xfer, last_pix, push, pop;

  assign ram_write      = 1'b0;
  assign ram_byteenable = 4'hF;
  assign ram_clken      = 1'b1;
  assign ram_address    = rd_addr_q;
  assign busy           = (state_q != S_IDLE);

  assign pix_valid = (count_q != '0);
  assign pix_data  = half_q ? mem_q[rd_ptr_q][31:16] : mem_q[rd_ptr_q][15:0];
  assign last_pix  = (pix_cnt_q == LAST_PIX);
  assign pix_sop   = pix_valid & (pix_cnt_q == '0);
  assign pix_eop   = pix_valid & last_pix;
  assign xfer      = pix_valid & pix_ready;
  // RAM q is captured exactly one cycle after its strobe; the hi half retires a word
  assign push      = inflight_q;
  assign pop       = xfer & half_q;

  // Frame sequencing and credit-limited read issue
  always_comb begin
    state_d        = state_q;
    rd_addr_d      = rd_addr_q;
    ram_chipselect = 1'b0;
    frame_done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          rd_addr_d = '0;
        end
      end
      S_RUN: begin
        // words buffered plus the one still coming back must leave a free slot
        if ((count_q + CNT_W'(inflight_q)) < DEPTH_C) begin
          ram_chipselect = 1'b1;
          if (rd_addr_q == LAST_WORD) begin
            state_d = S_DRAIN;
          end else begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (xfer && last_pix) begin
          frame_done = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO bookkeeping, half-select and pixel position
  always_comb begin
    inflight_d = ram_chipselect;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    half_d     = half_q ^ xfer;
    pix_cnt_d  = pix_cnt_q;
    if (xfer) pix_cnt_d = last_pix ? '0 : pix_cnt_q + PIX_W'(1);
  end

  // Control registers; reset drops any read still in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rd_addr_q  <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      half_q     <= 1'b0;
      pix_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      half_q     <= half_d;
      pix_cnt_q  <= pix_cnt_d;
    end
  end

  // Word storage; contents are don't-care while the count says empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ram_readdata;
  end

  // A push into a full FIFO means the credit rule was broken
  always_ff @(posedge clk) begin
    if (!reset) assert (!(push && !pop && (count_q == DEPTH_C)));
  end
endmodule

// File: tb/tb_raytracing_fb_scanout.sv
// Bench for raytracing_fb_scanout: two instances (256 words / depth 4 and
// 8 words / depth 2) against a stream-level model of the expected pixels.
module tb_raytracing_fb_scanout;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst [2];
  logic start [2];
  logic rdy [2];
  logic cont_chk [2];

  int tb_checks = 0, tb_pass = 0;

  task automatic tchk(input string name, input int act, input int exp);
    tb_checks++;
    if (act == exp) tb_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int N = (g == 0) ? 256 : 8;
    localparam int D = (g == 0) ? 4 : 2;
    logic busy, fdone, cs, wr, clken, valid, sop, eop;
    logic [15:0] addr, pdata;
    logic [3:0]  be;
    logic [31:0] q;
    int checks = 0, pass = 0;
    int k = 0, issued = 0, popped = 0, frames = 0, fd_seen = 0, xfers = 0;
    int start_cyc = 0;
    bit mbusy = 1'b0, seen_valid = 1'b0, rst_q = 1'b0, stall = 1'b0;
    logic [15:0] last_data = '0;
    logic last_sop = 1'b0, last_eop = 1'b0;

    raytracing_fb_scanout #(.NUM_WORDS(N), .ADDR_W(16), .FIFO_DEPTH(D)) dut (
      .clk(clk), .reset(rst[g]), .start(start[g]), .busy(busy), .frame_done(fdone),
      .ram_address(addr), .ram_chipselect(cs), .ram_write(wr), .ram_byteenable(be),
      .ram_clken(clken), .ram_readdata(q), .pix_data(pdata), .pix_valid(valid),
      .pix_ready(rdy[g]), .pix_sop(sop), .pix_eop(eop)
    );

    // RAM: word i = {~i, i}; garbage on cycles that were not strobed
    always @(posedge clk) q <= cs ? {~addr, addr} : $urandom;
    always @(posedge clk) rst_q <= rst[g];

    task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) pass++;
      else $display("FAIL %s dut%0d: got %0h expected %0h", name, g, act, exp);
    endtask

    always @(negedge clk) begin
      int i, e;
      bit done_now;
      done_now = 1'b0;
      if (rst_q) begin
        chk("rst_valid", valid, 0); chk("rst_busy", busy, 0); chk("rst_cs", cs, 0);
        chk("rst_addr", addr, 0); chk("rst_sop", sop, 0); chk("rst_done", fdone, 0);
        chk("rst_const", {wr, be, clken}, 6'b0_1111_1);
        k = 0; issued = 0; popped = 0; mbusy = 1'b0; stall = 1'b0; seen_valid = 1'b0;
      end
      if (!rst[g]) begin
        chk("busy", busy, mbusy);
        if (stall) begin
          chk("hold_valid", valid, 1); chk("hold_data", pdata, last_data);
          chk("hold_sop", sop, last_sop); chk("hold_eop", eop, last_eop);
        end
        if (cs) begin
          chk("credit", (issued - popped) < D, 1);
          chk("rd_addr", addr, issued);
          issued++;
        end
        if (mbusy && !seen_valid && valid) begin
          seen_valid = 1'b1;
          chk("first_valid_lat", cyc - start_cyc, 3);
        end
        if (cont_chk[g] && mbusy && seen_valid) chk("no_gap", valid, 1);
        if (valid && rdy[g]) begin
          i = k / 2;
          e = (k % 2 == 0) ? (i & 'hFFFF) : (~i & 'hFFFF);
          chk("pix_data", pdata, e);
          chk("sop", sop, k == 0);
          chk("eop", eop, k == 2 * N - 1);
          chk("frame_done", fdone, k == 2 * N - 1);
          if (k % 2 == 1) popped++;
          k++; xfers++;
          if (k == 2 * N) begin
            k = 0; issued = 0; popped = 0; frames++; done_now = 1'b1;
          end
        end else begin
          chk("no_done", fdone, 0);
        end
        if (fdone) fd_seen++;
        stall = valid && !rdy[g];
        last_data = pdata; last_sop = sop; last_eop = eop;
        if (!mbusy && start[g]) begin
          mbusy = 1'b1; start_cyc = cyc; seen_valid = 1'b0;
        end else if (done_now) begin
          mbusy = 1'b0;
        end
      end
    end
  end

  task automatic pulse_start(input int g);
    @(posedge clk); #1 start[g] = 1'b1;
    @(posedge clk); #1 start[g] = 1'b0;
  endtask

  task automatic wait_frames_a(input int n, input int limit);
    int c = 0;
    while (u[0].frames < n && c < limit) begin @(posedge clk); c++; end
    #1 tchk("frames_a", u[0].frames, n);
  endtask

  initial begin
    int base, c, last, total, passed;
    for (int g = 0; g < 2; g++) begin
      rst[g] = 1'b1; start[g] = 1'b0; rdy[g] = 1'b1; cont_chk[g] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst[0] = 1'b0; rst[1] = 1'b0;
    repeat (2) @(posedge clk);

    // full-rate frame with a second start at cycle 50 that must be ignored
    #1 cont_chk[0] = 1'b1;
    pulse_start(0);
    repeat (48) @(posedge clk);
    #1 start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    wait_frames_a(1, 2000);
    tchk("fd_one", u[0].fd_seen, 1);
    tchk("xfers_one", u[0].xfers, 512);
    repeat (20) @(posedge clk);
    #1 tchk("idle_after", u[0].busy, 0);
    tchk("no_extra_frame", u[0].xfers, 512);
    cont_chk[0] = 1'b0;

    // random 30% ready duty
    pulse_start(0);
    c = 0;
    while (u[0].frames < 2 && c < 5000) begin
      @(posedge clk); #1 rdy[0] = ($urandom_range(0, 9) < 3);
      c++;
    end
    rdy[0] = 1'b1;
    tchk("frames_rand", u[0].frames, 2);
    tchk("fd_two", u[0].fd_seen, 2);
    repeat (5) @(posedge clk);

    // long stall on the first pixel
    #1 rdy[0] = 1'b0;
    pulse_start(0);
    c = 0;
    while (!u[0].valid && c < 20) begin @(posedge clk); #1 c++; end
    repeat (100) @(posedge clk);
    #1 tchk("stall_issued_le4", u[0].issued <= 4, 1);
    tchk("stall_valid", u[0].valid, 1);
    tchk("stall_data", u[0].pdata, 16'h0000);
    rdy[0] = 1'b1;
    @(posedge clk); #1 tchk("resume_data", u[0].pdata, 16'hFFFF);
    wait_frames_a(3, 2000);
    repeat (5) @(posedge clk);

    // reset mid-frame, then a clean restart
    base = u[0].xfers;
    pulse_start(0);
    c = 0;
    while (u[0].xfers < base + 300 && c < 2000) begin @(posedge clk); c++; end
    #1 tchk("reached_300", u[0].xfers, base + 300);
    rst[0] = 1'b1;
    @(posedge clk); #1 rst[0] = 1'b0;
    tchk("rst_no_done", u[0].fd_seen, 3);
    pulse_start(0);
    wait_frames_a(4, 2000);
    tchk("fd_four", u[0].fd_seen, 4);

    // small instance: three back-to-back frames
    cont_chk[1] = 1'b1;
    last = 0;
    pulse_start(1);
    for (int n = 0; n < 500 && u[1].frames < 3; n++) begin
      @(posedge clk); #1;
      start[1] = (u[1].fd_seen != last) && (u[1].fd_seen < 3);
      last = u[1].fd_seen;
    end
    start[1] = 1'b0;
    tchk("frames_b", u[1].frames, 3);
    tchk("xfers_b", u[1].xfers, 48);
    repeat (5) @(posedge clk);

    total  = tb_checks + u[0].checks + u[1].checks;
    passed = tb_pass + u[0].pass + u[1].pass;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
